// File: rtl/riscv_multi_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, memory, ALU and
// branch steps and drives datapath mux selects and register/memory strobes.
module riscv_multi_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  input  logic       ovf,
  input  logic       carry,
  input  logic       mem_rdy,
  output logic       pc_we,
  output logic       ir_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       mem_req,
  output logic       reg_we,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [1:0] res_src,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_EXECU  = 4'd8;
  localparam logic [3:0] S_EXECJR = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_ALUWB  = 4'd12;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  logic [3:0] state, next_state;
  logic [3:0] exec_alu;
  logic       br_take, br_ok;
  logic       pc_we_s, ir_we_s, mem_we_s, mem_req_s, reg_we_s, illegal_s;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // funct7b5 means SUB only for register-register ops; addi ignores it
  always_comb begin
    case (funct3)
      3'b000:  exec_alu = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_alu = ALU_SLL;
      3'b010:  exec_alu = ALU_SLT;
      3'b011:  exec_alu = ALU_SLTU;
      3'b100:  exec_alu = ALU_XOR;
      3'b101:  exec_alu = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  exec_alu = ALU_OR;
      default: exec_alu = ALU_AND;
    endcase
  end

  always_comb begin
    br_ok   = 1'b1;
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = zero;
      3'b001:  br_take = ~zero;
      3'b100:  br_take = neg ^ ovf;
      3'b101:  br_take = ~(neg ^ ovf);
      3'b110:  br_take = ~carry;
      3'b111:  br_take = carry;
      default: br_ok   = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    pc_we_s    = 1'b0;
    ir_we_s    = 1'b0;
    mem_we_s   = 1'b0;
    mem_req_s  = 1'b0;
    reg_we_s   = 1'b0;
    illegal_s  = 1'b0;
    adr_src    = 1'b0;
    imm_src    = IMM_I;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_ctrl   = ALU_ADD;
    res_src    = 2'd0;
    case (state)
      S_FETCH: begin
        mem_req_s = 1'b1;
        alu_src_b = 2'd2;
        res_src   = 2'd2;
        ir_we_s   = mem_rdy;
        pc_we_s   = mem_rdy;
        if (mem_rdy) next_state = S_DECODE;
      end
      // Branch/jal targets are precomputed here as old_pc + imm
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        if (op == OP_BR)       imm_src = IMM_B;
        else if (op == OP_JAL) imm_src = IMM_J;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_LUI, OP_AUIPC:  next_state = S_EXECU;
          OP_JALR:           next_state = S_EXECJR;
          OP_JAL:            next_state = S_JUMP;
          OP_BR:             next_state = S_BRANCH;
          default: begin
            illegal_s  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
        next_state = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
        if (mem_rdy) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        res_src    = 2'd1;
        reg_we_s   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        adr_src   = 1'b1;
        if (mem_rdy) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'd2;
        alu_ctrl   = exec_alu;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        alu_ctrl   = exec_alu;
        next_state = S_ALUWB;
      end
      S_EXECU: begin
        alu_src_a  = (op == OP_LUI) ? 2'd3 : 2'd1;
        alu_src_b  = 2'd1;
        imm_src    = IMM_U;
        next_state = S_ALUWB;
      end
      S_EXECJR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        next_state = S_JUMP;
      end
      // PC takes the stored target while the ALU forms the link address
      S_JUMP: begin
        pc_we_s    = 1'b1;
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        next_state = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'd2;
        alu_ctrl   = ALU_SUB;
        imm_src    = IMM_B;
        pc_we_s    = br_ok & br_take;
        illegal_s  = ~br_ok;
        next_state = S_FETCH;
      end
      S_ALUWB: begin
        reg_we_s   = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Reset silences every strobe even mid-stall
  assign pc_we   = pc_we_s   & ~rst;
  assign ir_we   = ir_we_s   & ~rst;
  assign mem_we  = mem_we_s  & ~rst;
  assign mem_req = mem_req_s & ~rst;
  assign reg_we  = reg_we_s  & ~rst;
  assign illegal = illegal_s & ~rst;

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Randomized bench for riscv_multi_ctrl: builds the expected per-cycle output
// sequence of each instruction from its class and compares every cycle.
module tb_riscv_multi_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_LUI = 4;
  localparam int C_AUIPC = 5, C_JALR = 6, C_JAL = 7, C_BR = 8, C_ILL = 9;

  localparam int A_ADD = 0, A_SLL = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4;
  localparam int A_SRL = 5, A_OR = 6, A_AND = 7, A_SUB = 8, A_SRA = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg, ovf, carry, mem_rdy;
  logic       pc_we, ir_we, adr_src, mem_we, mem_req, reg_we, illegal;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, res_src;
  logic [3:0] alu_ctrl;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       rst, mem_rdy, zero, neg, ovf, carry, f7;
    logic [6:0] op;
    logic [2:0] f3;
    int pc_we, ir_we, adr_src, mem_we, mem_req, reg_we;
    int imm_src, a, b, alu, res_src, illegal;
  } cyc_t;

  cyc_t       q[$];
  logic [6:0] curOp;
  logic [2:0] curF3;
  logic       curF7;
  int         aluByF3[8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};

  riscv_multi_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .ovf(ovf), .carry(carry), .mem_rdy(mem_rdy),
    .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src), .mem_we(mem_we),
    .mem_req(mem_req), .reg_we(reg_we), .imm_src(imm_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .res_src(res_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmpField(input string n, input string f, input logic [7:0] obs, input int exp);
    if (exp >= 0) checkOutput({n, ".", f}, obs, 8'(exp));
  endtask

  function automatic bit isValidOp(logic [6:0] o);
    return o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JALR, OP_JAL, OP_BR};
  endfunction

  // Quiet cycle: no strobes, selects unconstrained, unrelated inputs random
  function automatic cyc_t blank(string name);
    cyc_t c;
    c.name = name; c.rst = 1'b0;
    c.mem_rdy = 1'($urandom_range(0, 1));
    c.zero = 1'($urandom_range(0, 1)); c.neg = 1'($urandom_range(0, 1));
    c.ovf = 1'($urandom_range(0, 1)); c.carry = 1'($urandom_range(0, 1));
    c.op = curOp; c.f3 = curF3; c.f7 = curF7;
    c.pc_we = 0; c.ir_we = 0; c.mem_we = 0; c.mem_req = 0; c.reg_we = 0; c.illegal = 0;
    c.adr_src = -1; c.imm_src = -1; c.a = -1; c.b = -1; c.alu = -1; c.res_src = -1;
    return c;
  endfunction

  function automatic cyc_t aluStep(string name, int a, int b, int imm, int alu);
    cyc_t c = blank(name);
    c.a = a; c.b = b; c.imm_src = imm; c.alu = alu;
    return c;
  endfunction

  function automatic int aluRef(bit isR, logic [2:0] f3, logic f7);
    int r = aluByF3[f3];
    if (f3 == 3'd0 && isR && f7) r = A_SUB;
    if (f3 == 3'd5 && f7) r = A_SRA;
    return r;
  endfunction

  function automatic void addMem(string name, bit wr, int stalls);
    for (int i = 0; i <= stalls; i++) begin
      cyc_t c = blank(name);
      c.mem_rdy = (i == stalls);
      c.mem_req = 1; c.adr_src = 1; c.mem_we = wr;
      q.push_back(c);
    end
  endfunction

  function automatic void addWb(string name, int res);
    cyc_t c = blank(name);
    c.reg_we = 1; c.res_src = res;
    q.push_back(c);
  endfunction

  function automatic void buildInstr(int cls, logic [2:0] f3, logic f7, int fs, int ms,
                                     int forceCarry, logic [6:0] illOp);
    cyc_t c;
    case (cls)
      C_LOAD: curOp = OP_LOAD;   C_STORE: curOp = OP_STORE; C_R: curOp = OP_R;
      C_I: curOp = OP_I;         C_LUI: curOp = OP_LUI;     C_AUIPC: curOp = OP_AUIPC;
      C_JALR: curOp = OP_JALR;   C_JAL: curOp = OP_JAL;     C_BR: curOp = OP_BR;
      default: curOp = illOp;
    endcase
    curF3 = f3; curF7 = f7;
    for (int i = 0; i <= fs; i++) begin
      c = aluStep("FETCH", 0, 2, -1, A_ADD);
      c.mem_rdy = (i == fs);
      c.mem_req = 1; c.adr_src = 0; c.res_src = 2;
      c.ir_we = c.mem_rdy; c.pc_we = c.mem_rdy;
      q.push_back(c);
    end
    c = aluStep("DECODE", 1, 1, (cls == C_BR) ? 2 : (cls == C_JAL) ? 3 : 0, A_ADD);
    c.illegal = (cls == C_ILL);
    q.push_back(c);
    case (cls)
      C_LOAD: begin
        q.push_back(aluStep("MEMADR", 2, 1, 0, A_ADD));
        addMem("MEMRD", 1'b0, ms);
        addWb("MEMWB", 1);
      end
      C_STORE: begin
        q.push_back(aluStep("MEMADR", 2, 1, 1, A_ADD));
        addMem("MEMWR", 1'b1, ms);
      end
      C_R: begin
        q.push_back(aluStep("EXECR", 2, 0, -1, aluRef(1'b1, f3, f7)));
        addWb("ALUWB", 0);
      end
      C_I: begin
        q.push_back(aluStep("EXECI", 2, 1, 0, aluRef(1'b0, f3, f7)));
        addWb("ALUWB", 0);
      end
      C_LUI, C_AUIPC: begin
        q.push_back(aluStep("EXECU", (cls == C_LUI) ? 3 : 1, 1, 4, A_ADD));
        addWb("ALUWB", 0);
      end
      C_JALR, C_JAL: begin
        if (cls == C_JALR) q.push_back(aluStep("EXECJR", 2, 1, 0, A_ADD));
        c = aluStep("JUMP", 1, 2, -1, A_ADD);
        c.pc_we = 1; c.res_src = 0;
        q.push_back(c);
        addWb("ALUWB", 0);
      end
      C_BR: begin
        c = aluStep("BRANCH", 2, 0, -1, A_SUB);
        c.res_src = 0;
        if (forceCarry >= 0) c.carry = 1'(forceCarry);
        case (f3)
          3'd0: c.pc_we = c.zero;
          3'd1: c.pc_we = !c.zero;
          3'd4: c.pc_we = (c.neg != c.ovf);
          3'd5: c.pc_we = (c.neg == c.ovf);
          3'd6: c.pc_we = !c.carry;
          3'd7: c.pc_we = c.carry;
          default: begin c.pc_we = 0; c.illegal = 1; end
        endcase
        q.push_back(c);
      end
      default: ;
    endcase
  endfunction

  // Plays the expected queue one cycle at a time; entered just after a rising edge
  task automatic applyStimulus();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      rst = c.rst; op = c.op; funct3 = c.f3; funct7b5 = c.f7; mem_rdy = c.mem_rdy;
      zero = c.zero; neg = c.neg; ovf = c.ovf; carry = c.carry;
      #3;
      cmpField(c.name, "pc_we", 8'(pc_we), c.pc_we);
      cmpField(c.name, "ir_we", 8'(ir_we), c.ir_we);
      cmpField(c.name, "mem_we", 8'(mem_we), c.mem_we);
      cmpField(c.name, "mem_req", 8'(mem_req), c.mem_req);
      cmpField(c.name, "reg_we", 8'(reg_we), c.reg_we);
      cmpField(c.name, "illegal", 8'(illegal), c.illegal);
      cmpField(c.name, "adr_src", 8'(adr_src), c.adr_src);
      cmpField(c.name, "imm_src", 8'(imm_src), c.imm_src);
      cmpField(c.name, "alu_src_a", 8'(alu_src_a), c.a);
      cmpField(c.name, "alu_src_b", 8'(alu_src_b), c.b);
      cmpField(c.name, "alu_ctrl", 8'(alu_ctrl), c.alu);
      cmpField(c.name, "res_src", 8'(res_src), c.res_src);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc_t       c;
    logic [6:0] ill;
    rst = 1'b1; op = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; mem_rdy = 1'b1;
    zero = 1'b0; neg = 1'b0; ovf = 1'b0; carry = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset.pc_we", 8'(pc_we), 8'd0);
    checkOutput("reset.ir_we", 8'(ir_we), 8'd0);
    checkOutput("reset.mem_req", 8'(mem_req), 8'd0);
    checkOutput("reset.mem_we", 8'(mem_we), 8'd0);
    checkOutput("reset.reg_we", 8'(reg_we), 8'd0);
    @(posedge clk);
    #1;

    buildInstr(C_R, 3'd0, 1'b1, 0, 0, -1, 7'h7f);
    buildInstr(C_BR, 3'd7, 1'b0, 0, 0, 1, 7'h7f);
    buildInstr(C_BR, 3'd7, 1'b0, 0, 0, 0, 7'h7f);
    buildInstr(C_LOAD, 3'd2, 1'b0, 0, 3, -1, 7'h7f);
    buildInstr(C_I, 3'd5, 1'b1, 2, 0, -1, 7'h7f);
    buildInstr(C_ILL, 3'd0, 1'b0, 0, 0, -1, 7'b1111111);
    buildInstr(C_JAL, 3'd0, 1'b0, 0, 0, -1, 7'h7f);
    buildInstr(C_JALR, 3'd0, 1'b0, 1, 0, -1, 7'h7f);
    buildInstr(C_LUI, 3'd0, 1'b0, 0, 0, -1, 7'h7f);
    buildInstr(C_AUIPC, 3'd0, 1'b0, 0, 0, -1, 7'h7f);
    buildInstr(C_BR, 3'd2, 1'b0, 0, 0, -1, 7'h7f);

    // Store stalled in the write phase, then reset arrives mid-stall
    buildInstr(C_STORE, 3'd2, 1'b0, 0, 2, -1, 7'h7f);
    q.delete(q.size() - 1);
    q.delete(q.size() - 1);
    c = blank("RSTWR");
    c.rst = 1'b1; c.mem_rdy = 1'b0;
    q.push_back(c);
    buildInstr(C_STORE, 3'd2, 1'b0, 0, 1, -1, 7'h7f);
    applyStimulus();

    for (int n = 0; n < 80; n++) begin
      do ill = 7'($urandom); while (isValidOp(ill));
      buildInstr($urandom_range(0, 9), 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 2), -1, ill);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
